vga_pgen_param: RTL and testbench
=================================

# vga_pgen_param

Parametrised pixel generator for the VGA/LCD core. It runs horizontal and vertical timing state machines and pops pixel words from the line FIFO. Each word is formatted per a frame-latched colour mode (direct, greyscale, or horizontal pixel doubling) and drives registered RGB, sync and blank outputs. The block sits between the line FIFO and the pads, in the pixel-clock domain, and generates the eol/eof strobes used by the fetch side.

## Interface
- CDW, 8: width of one colour channel; FIFO word is 3*CDW bits as {R,G,B}
- HW, 12: width of horizontal timing registers and counter
- VW, 11: width of vertical timing registers and counter
- pclk_i  in  1  pixel clock, only clock
- nrst_i  in  1  asynchronous, active-low reset
- ctrl_ven  in  1  video enable
- ctrl_mode  in  2  00 direct, 01 grey, 10 pixel-double, 11 treated as 00
- ctrl_hsyncl, ctrl_vsyncl, ctrl_blankl  in  1 each  output polarity; 1 = active-low
- thsync, thgdel, thgate, thlen  in  HW each  sync, back-porch and active lengths minus 1; thlen = total line cycles minus 1
- tvsync, tvgdel, tvgate, tvlen  in  VW each  same quantities, in lines
- fifo_q  in  3*CDW  line FIFO data, valid the cycle after fifo_rreq
- fifo_empty  in  1  line FIFO empty
- fifo_rreq  out  1  FIFO pop, one word per assertion
- r_o, g_o, b_o  out  CDW each  pixel data
- hsync_o, vsync_o, blank_o  out  1 each  sync and blank after polarity
- eol_o, eof_o  out  1 each  one-cycle end-of-line / end-of-frame strobes
- underrun_o  out  1  sticky FIFO-underrun flag
- underrun_clr  in  1  clears underrun_o

## Operation
- Horizontal FSM states run in order H_SYNC, H_BACK, H_ACT, H_FRONT, then wrap.
  - H_SYNC lasts thsync+1 cycles, H_BACK thgdel+1, H_ACT thgate+1.
  - H_FRONT lasts thlen−thsync−thgdel−thgate−2 cycles, computed in HW+2 bits.
  - If that result is ≤0, H_FRONT lasts 1 cycle.
- Vertical FSM states run V_SYNC, V_BACK, V_ACT, V_FRONT with the same rules, counted in lines. It advances only on the last H_FRONT cycle.
- Internal flags: ihsync = H_SYNC; ivsync = V_SYNC; active = H_ACT & V_ACT; iblank = ~active.
- eol_o pulses on the last cycle of H_FRONT. eof_o pulses when eol_o coincides with the last line of V_FRONT.
- Pixel slot: every active cycle in modes 00/01; only even active cycles in mode 10. The phase bit clears at the first H_ACT cycle of each line.
- fifo_rreq = slot & ~fifo_empty, combinational from the current state.
- If a slot sees fifo_empty:
  - no pop occurs;
  - the pixel(s) for that slot output as 0;
  - underrun_o sets.
- underrun_o stays set until underrun_clr. If a set and a clear happen in the same cycle, the set wins.
- Formatting in the stage after the pop:
  - mode 00: {r,g,b} = fifo_q.
  - mode 01: r = g = b = fifo_q[CDW-1:0].
  - mode 10: the popped word is held and shown for 2 consecutive pixels.
- ctrl_mode is sampled into an internal register at eof_o and at ctrl_ven rise. A mid-frame change has no effect until the next frame.
- ctrl_ven low:
  - both FSMs are held at their first cycle of H_SYNC / line 0 of V_SYNC;
  - no pops; phase clears;
  - ihsync = ivsync = 0, iblank = 1, rgb = 0.
- ctrl_ven rise: timing starts at H_SYNC cycle 0 of V_SYNC line 0 on the next edge.
- ctrl_ven fall mid-line: takes effect on the next edge; any in-flight pixel is dropped.
- Timing registers are sampled live. Software changes them only while ctrl_ven = 0.

## Timing
- Stage 0 is the FSM state, with fifo_rreq, eol_o and eof_o combinational from it. Stage 1 captures fifo_q and formats it. Stage 2 is the output registers.
- r_o/g_o/b_o appear 2 cycles after the slot's stage-0 cycle.
- ihsync, ivsync and iblank are delayed by 2 registers so they stay aligned with the pixels.
- Output equations: hsync_o = ihsync ^ ctrl_hsyncl, vsync_o = ivsync ^ ctrl_vsyncl, blank_o = iblank ^ ctrl_blankl. Each is registered at stage 2.
- Reset values: every output and internal register is 0; the FSMs reset to H_SYNC/V_SYNC with counters at 0.
- First edge after reset release, with ctrl_ven = 0: blank_o = 1 ^ ctrl_blankl.
- Reset asserted mid-operation clears everything immediately and asynchronously.

## Test plan
- Baseline timing, CDW=8, mode 00, ctrl_ven = 1. Settings: thsync=1, thgdel=1, thgate=3, thlen=9; tvsync=0, tvgdel=0, tvgate=1, tvlen=4; polarities 0. Expected: 10-cycle lines with hsync_o high 2 cycles and blank_o low 4 cycles per active line. Frame = 5 lines; eof_o pulses once per 50 cycles.
- Direct data: FIFO holds 0x112233, 0x445566, … → fifo_rreq high in 4 consecutive cycles per active line; r_o=0x11, g_o=0x22, b_o=0x33 two cycles after the first pop.
- Grey and doubling: mode 01 with word 0xABCDEF → r_o = g_o = b_o = 0xEF. Mode 10 → 2 pops per line, each word shown for 2 pixels. A change from 00 to 10 written mid-frame is applied only after eof_o.
- Underrun: fifo_empty forced high in the 2nd slot → no pop; that pixel is 0x000000 and underrun_o = 1 until underrun_clr. Setting underrun_clr and a new underrun in the same cycle leaves underrun_o = 1.
- Front-porch clamp and polarity: thlen=5 with other values as in the baseline → H_FRONT is 1 cycle, line = 9 cycles. ctrl_hsyncl=1 → hsync_o low during sync.
- Reset and enable: nrst_i pulsed mid-active → all outputs 0 immediately. ctrl_ven dropped mid-line → no fifo_rreq from the next edge and blank_o active after 2 cycles; re-enable restarts at H_SYNC/V_SYNC line 0.

Source files
------------

// File: rtl/vga_pgen_param_if.sv
// Line-FIFO read port between the pixel generator and the line FIFO.
interface vga_pgen_param_if #(
    parameter int unsigned CDW = 8
) ();
    logic [3*CDW-1:0] fifo_q;
    logic             fifo_empty;
    logic             fifo_rreq;

    // Pixel generator side: issues pops, receives data one cycle later.
    modport master (
        output fifo_rreq,
        input  fifo_q,
        input  fifo_empty
    );

    // FIFO side.
    modport slave (
        input  fifo_rreq,
        output fifo_q,
        output fifo_empty
    );
endinterface

// File: rtl/vga_pgen_param.sv
// Pixel generator: horizontal/vertical timing FSMs, line-FIFO pops, colour-mode
// formatting and registered RGB/sync/blank outputs. Three stages: FSM state (0),
// FIFO data capture/format (1), output registers (2).
module vga_pgen_param #(
    parameter int unsigned CDW = 8,
    parameter int unsigned HW  = 12,
    parameter int unsigned VW  = 11
) (
    input  logic              pclk_i,
    input  logic              nrst_i,
    input  logic              ctrl_ven,
    input  logic [1:0]        ctrl_mode,
    input  logic              ctrl_hsyncl,
    input  logic              ctrl_vsyncl,
    input  logic              ctrl_blankl,
    input  logic [HW-1:0]     thsync,
    input  logic [HW-1:0]     thgdel,
    input  logic [HW-1:0]     thgate,
    input  logic [HW-1:0]     thlen,
    input  logic [VW-1:0]     tvsync,
    input  logic [VW-1:0]     tvgdel,
    input  logic [VW-1:0]     tvgate,
    input  logic [VW-1:0]     tvlen,
    vga_pgen_param_if.master  fifo,
    output logic [CDW-1:0]    r_o,
    output logic [CDW-1:0]    g_o,
    output logic [CDW-1:0]    b_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              blank_o,
    output logic              eol_o,
    output logic              eof_o,
    output logic              underrun_o,
    input  logic              underrun_clr
);

    localparam logic [1:0] H_SYNC  = 2'd0;
    localparam logic [1:0] H_BACK  = 2'd1;
    localparam logic [1:0] H_ACT   = 2'd2;
    localparam logic [1:0] H_FRONT = 2'd3;

    localparam logic [1:0] V_SYNC  = 2'd0;
    localparam logic [1:0] V_BACK  = 2'd1;
    localparam logic [1:0] V_ACT   = 2'd2;
    localparam logic [1:0] V_FRONT = 2'd3;

    localparam logic [1:0] MODE_GREY = 2'b01;
    localparam logic [1:0] MODE_DBL  = 2'b10;

    // Stage 0 state
    logic          ven_q;
    logic [1:0]    hstate_q, hstate_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [1:0]    vstate_q, vstate_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          phase_q, phase_d;
    logic [1:0]    mode_q, mode_d;
    logic          underrun_q, underrun_d;

    // Stage 1 state
    logic             s1_act_q, s1_hs_q, s1_vs_q;
    logic             s1_slot_q, s1_pop_q, s1_rep_q;
    logic [3*CDW-1:0] hold_q, hold_d;
    logic [3*CDW-1:0] pix_s1;

    // Front-porch lengths; a non-positive result clamps to a single cycle
    logic [HW+1:0] hf_len;
    logic [HW-1:0] hf_last;
    logic [VW+1:0] vf_len;
    logic [VW-1:0] vf_last;

    assign hf_len  = {2'b00, thlen} - {2'b00, thsync} - {2'b00, thgdel} - {2'b00, thgate}
                   - (HW+2)'(2);
    assign hf_last = (hf_len[HW+1] || (hf_len == '0)) ? '0 : (hf_len[HW-1:0] - HW'(1));
    assign vf_len  = {2'b00, tvlen} - {2'b00, tvsync} - {2'b00, tvgdel} - {2'b00, tvgate}
                   - (VW+2)'(2);
    assign vf_last = (vf_len[VW+1] || (vf_len == '0)) ? '0 : (vf_len[VW-1:0] - VW'(1));

    logic [HW-1:0] h_lim;
    logic [VW-1:0] v_lim;
    logic          h_end, v_end;

    // Last count of the current horizontal and vertical state
    always_comb begin
        h_lim = hf_last;
        unique case (hstate_q)
            H_SYNC:  h_lim = thsync;
            H_BACK:  h_lim = thgdel;
            H_ACT:   h_lim = thgate;
            default: h_lim = hf_last;
        endcase
        v_lim = vf_last;
        unique case (vstate_q)
            V_SYNC:  v_lim = tvsync;
            V_BACK:  v_lim = tvgdel;
            V_ACT:   v_lim = tvgate;
            default: v_lim = vf_last;
        endcase
    end

    assign h_end = (hcnt_q == h_lim);
    assign v_end = (vcnt_q == v_lim);

    logic active, ihsync, ivsync, dbl, slot, under_set;

    assign active    = ven_q && (hstate_q == H_ACT) && (vstate_q == V_ACT);
    assign ihsync    = ven_q && (hstate_q == H_SYNC);
    assign ivsync    = ven_q && (vstate_q == V_SYNC);
    assign dbl       = (mode_q == MODE_DBL);
    assign slot      = active && (!dbl || !phase_q);
    assign under_set = slot && fifo.fifo_empty;

    assign fifo.fifo_rreq = slot && !fifo.fifo_empty;
    assign eol_o          = ven_q && (hstate_q == H_FRONT) && h_end;
    assign eof_o          = eol_o && (vstate_q == V_FRONT) && v_end;
    assign underrun_o     = underrun_q;

    // Timing FSMs, phase, frame-latched mode and sticky underrun next state
    always_comb begin
        hstate_d   = hstate_q;
        hcnt_d     = hcnt_q;
        vstate_d   = vstate_q;
        vcnt_d     = vcnt_q;
        phase_d    = 1'b0;
        mode_d     = mode_q;
        underrun_d = underrun_q;

        // Held at the frame origin until enable has been seen for one edge
        if (!ctrl_ven || !ven_q) begin
            hstate_d = H_SYNC;
            hcnt_d   = '0;
            vstate_d = V_SYNC;
            vcnt_d   = '0;
        end else begin
            if (h_end) begin
                hstate_d = hstate_q + 2'd1;
                hcnt_d   = '0;
            end else begin
                hcnt_d = hcnt_q + HW'(1);
            end
            if (eol_o) begin
                if (v_end) begin
                    vstate_d = vstate_q + 2'd1;
                    vcnt_d   = '0;
                end else begin
                    vcnt_d = vcnt_q + VW'(1);
                end
            end
            phase_d = active ? !phase_q : 1'b0;
        end

        if ((ctrl_ven && !ven_q) || eof_o) begin
            mode_d = ctrl_mode;
        end

        // Set has priority over clear
        if (under_set) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    // Stage 0 registers
    always_ff @(posedge pclk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            ven_q      <= 1'b0;
            hstate_q   <= H_SYNC;
            hcnt_q     <= '0;
            vstate_q   <= V_SYNC;
            vcnt_q     <= '0;
            phase_q    <= 1'b0;
            mode_q     <= 2'b00;
            underrun_q <= 1'b0;
        end else begin
            ven_q      <= ctrl_ven;
            hstate_q   <= hstate_d;
            hcnt_q     <= hcnt_d;
            vstate_q   <= vstate_d;
            vcnt_q     <= vcnt_d;
            phase_q    <= phase_d;
            mode_q     <= mode_d;
            underrun_q <= underrun_d;
        end
    end

    // Stage 1 pixel: popped word formatted, repeated word in doubling mode, else 0
    always_comb begin
        pix_s1 = '0;
        if (s1_pop_q) begin
            if (mode_q == MODE_GREY) begin
                pix_s1 = {3{fifo.fifo_q[CDW-1:0]}};
            end else begin
                pix_s1 = fifo.fifo_q;
            end
        end else if (s1_rep_q) begin
            pix_s1 = hold_q;
        end
        // An underrun slot stores 0 so its repeated pixel is also 0
        hold_d = s1_slot_q ? pix_s1 : hold_q;
    end

    // Stage 1 registers; a falling enable drops whatever stage 0 was issuing
    always_ff @(posedge pclk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            s1_act_q  <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s1_slot_q <= 1'b0;
            s1_pop_q  <= 1'b0;
            s1_rep_q  <= 1'b0;
            hold_q    <= '0;
        end else begin
            s1_act_q  <= active && ctrl_ven;
            s1_hs_q   <= ihsync && ctrl_ven;
            s1_vs_q   <= ivsync && ctrl_ven;
            s1_slot_q <= slot && ctrl_ven;
            s1_pop_q  <= fifo.fifo_rreq && ctrl_ven;
            s1_rep_q  <= active && dbl && phase_q && ctrl_ven;
            hold_q    <= hold_d;
        end
    end

    // Stage 2 output registers with polarity applied
    always_ff @(posedge pclk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_o     <= '0;
            g_o     <= '0;
            b_o     <= '0;
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            blank_o <= 1'b0;
        end else begin
            r_o     <= pix_s1[3*CDW-1:2*CDW];
            g_o     <= pix_s1[2*CDW-1:CDW];
            b_o     <= pix_s1[CDW-1:0];
            hsync_o <= s1_hs_q ^ ctrl_hsyncl;
            vsync_o <= s1_vs_q ^ ctrl_vsyncl;
            blank_o <= !s1_act_q ^ ctrl_blankl;
        end
    end

endmodule

// File: tb/tb_vga_pgen_param.sv
// Directed bench for vga_pgen_param. Cycle k counts from the first H_SYNC
// cycle after enable; outputs at k show the stage-0 cycle k-2.
module tb_vga_pgen_param;

    localparam int unsigned CDW = 8;
    localparam int unsigned HW  = 12;
    localparam int unsigned VW  = 11;

    logic           pclk_i = 1'b0;
    logic           nrst_i = 1'b0;
    logic           ctrl_ven = 1'b0;
    logic [1:0]     ctrl_mode = 2'b00;
    logic           ctrl_hsyncl = 1'b0;
    logic           ctrl_vsyncl = 1'b0;
    logic           ctrl_blankl = 1'b0;
    logic [HW-1:0]  thsync = 12'd1, thgdel = 12'd1, thgate = 12'd3, thlen = 12'd9;
    logic [VW-1:0]  tvsync = 11'd0, tvgdel = 11'd0, tvgate = 11'd1, tvlen = 11'd4;
    logic [CDW-1:0] r_o, g_o, b_o;
    logic           hsync_o, vsync_o, blank_o, eol_o, eof_o, underrun_o;
    logic           underrun_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    vga_pgen_param_if #(.CDW(CDW)) fifo ();

    vga_pgen_param #(.CDW(CDW), .HW(HW), .VW(VW)) dut (
        .pclk_i       (pclk_i),
        .nrst_i       (nrst_i),
        .ctrl_ven     (ctrl_ven),
        .ctrl_mode    (ctrl_mode),
        .ctrl_hsyncl  (ctrl_hsyncl),
        .ctrl_vsyncl  (ctrl_vsyncl),
        .ctrl_blankl  (ctrl_blankl),
        .thsync       (thsync),
        .thgdel       (thgdel),
        .thgate       (thgate),
        .thlen        (thlen),
        .tvsync       (tvsync),
        .tvgdel       (tvgdel),
        .tvgate       (tvgate),
        .tvlen        (tvlen),
        .fifo         (fifo),
        .r_o          (r_o),
        .g_o          (g_o),
        .b_o          (b_o),
        .hsync_o      (hsync_o),
        .vsync_o      (vsync_o),
        .blank_o      (blank_o),
        .eol_o        (eol_o),
        .eof_o        (eof_o),
        .underrun_o   (underrun_o),
        .underrun_clr (underrun_clr)
    );

    always #5 pclk_i = ~pclk_i;

    // Word i of the FIFO stream: 0x112233, 0x445566, 0x778899, ...
    function automatic logic [23:0] word_of(input int i);
        logic [7:0] a, b, c;
        a = 8'((3 * i + 1) * 17);
        b = 8'((3 * i + 2) * 17);
        c = 8'((3 * i + 3) * 17);
        return {a, b, c};
    endfunction

    // Stage-0 active for a 5-line frame of L-cycle lines (lines 2,3; cycles 4..7)
    function automatic bit act_at(input int p, input int len);
        int a, line, c;
        a    = p % (5 * len);
        line = a / len;
        c    = a % len;
        return (line == 2 || line == 3) && c >= 4 && c <= 7;
    endfunction

    // Line FIFO model: data appears the cycle after a pop
    int         pop_cnt = 0;
    logic       fixed_en = 1'b0;
    logic [23:0] fixed_word = 24'hABCDEF;
    always @(posedge pclk_i) begin
        if (fifo.fifo_rreq) begin
            fifo.fifo_q <= fixed_en ? fixed_word : word_of(pop_cnt);
            pop_cnt     <= pop_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge pclk_i);
        #1;
    endtask

    // Disable for a few cycles, then enable; returns in cycle k = 0
    task automatic start(input logic [1:0] mode);
        ctrl_ven  = 1'b0;
        ctrl_mode = mode;
        repeat (3) tick();
        ctrl_ven = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [32:0] obs;
        fifo.fifo_empty = 1'b0;
        #2;
        obs = {fifo.fifo_rreq, eol_o, eof_o, underrun_o, hsync_o, vsync_o, blank_o,
               r_o, g_o, b_o};
        n_checks++;
        if (obs !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_values got %h want %h", obs, 33'd0);
        end
        repeat (2) @(posedge pclk_i);
        #2;
        nrst_i = 1'b1;
        tick();
        obs = {3'b000, underrun_o, hsync_o, vsync_o, blank_o, r_o, g_o, b_o};
        n_checks++;
        if (obs !== {6'b000000, 1'b1, 24'd0}) begin
            n_fail++;
            $display("FAIL first_edge_blank got %h want %h", obs, {6'b000000, 1'b1, 24'd0});
        end
    endtask

    task automatic test_baseline();
        int base, n, p;
        logic [23:0] exp_pix [0:99];
        logic [29:0] obs, exp;
        start(2'b00);
        base = pop_cnt;
        n    = 0;
        for (int k = 0; k < 100; k++) begin
            exp_pix[k] = 24'd0;
            if (act_at(k, 10)) begin
                exp_pix[k] = word_of(base + n);
                n++;
            end
            exp[29] = act_at(k, 10);
            exp[28] = (k % 10) == 9;
            exp[27] = (k % 50) == 49;
            if (k < 2) begin
                exp[26:0] = {3'b001, 24'd0};
            end else begin
                p = k - 2;
                exp[26]   = (p % 10) < 2;
                exp[25]   = ((p % 50) / 10) == 0;
                exp[24]   = !act_at(p, 10);
                exp[23:0] = exp_pix[p];
            end
            obs = {fifo.fifo_rreq, eol_o, eof_o, hsync_o, vsync_o, blank_o, r_o, g_o, b_o};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL baseline k=%0d got %h want %h", k, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_grey();
        logic [24:0] obs, exp;
        fixed_en = 1'b1;
        start(2'b01);
        for (int k = 0; k < 30; k++) begin
            if (k >= 24) begin
                exp = {(k <= 27), ((k >= 26) ? 24'hEFEFEF : 24'd0)};
                obs = {fifo.fifo_rreq, r_o, g_o, b_o};
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL grey k=%0d got %h want %h", k, obs, exp);
                end
            end
            tick();
        end
        fixed_en = 1'b0;
    endtask

    task automatic test_double();
        int base, p, a, c, idx;
        logic [24:0] obs, exp;
        start(2'b10);
        base = pop_cnt;
        for (int k = 0; k < 40; k++) begin
            c      = k % 10;
            exp[24] = act_at(k, 10) && ((c - 4) % 2 == 0);
            exp[23:0] = 24'd0;
            if (k >= 2 && act_at(k - 2, 10)) begin
                p   = k - 2;
                a   = p % 10;
                idx = (a - 4) / 2 + 2 * ((p / 10) - 2);
                exp[23:0] = word_of(base + idx);
            end
            obs = {fifo.fifo_rreq, r_o, g_o, b_o};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL double k=%0d got %h want %h", k, obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_mode_midframe();
        int pops_old, pops_new;
        pops_old = 0;
        pops_new = 0;
        start(2'b00);
        for (int k = 0; k < 80; k++) begin
            if (k == 30) ctrl_mode = 2'b10;
            if (k >= 34 && k <= 37 && fifo.fifo_rreq) pops_old++;
            if (k >= 74 && k <= 77 && fifo.fifo_rreq) pops_new++;
            if (k == 49) begin
                n_checks++;
                if (eof_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midframe_eof got %b want 1", eof_o);
                end
            end
            tick();
        end
        n_checks++;
        if (pops_old !== 4) begin
            n_fail++;
            $display("FAIL midframe_same_frame_pops got %0d want 4", pops_old);
        end
        n_checks++;
        if (pops_new !== 2) begin
            n_fail++;
            $display("FAIL midframe_next_frame_pops got %0d want 2", pops_new);
        end
    endtask

    task automatic test_underrun();
        int base, n;
        bit empty;
        logic [23:0] exp_pix [0:44];
        logic [25:0] obs, exp;
        ctrl_ven     = 1'b0;
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        start(2'b00);
        base = pop_cnt;
        n    = 0;
        for (int k = 0; k < 45; k++) begin
            empty           = (k == 25) || (k == 35);
            fifo.fifo_empty = empty;
            underrun_clr    = (k == 30) || (k == 35) || (k == 40);
            exp_pix[k]      = 24'd0;
            if (act_at(k, 10) && !empty) begin
                exp_pix[k] = word_of(base + n);
                n++;
            end
            exp[25]   = act_at(k, 10) && !empty;
            exp[24]   = (k >= 26 && k <= 30) || (k >= 36 && k <= 40);
            exp[23:0] = (k >= 2) ? exp_pix[k - 2] : 24'd0;
            #1;
            obs = {fifo.fifo_rreq, underrun_o, r_o, g_o, b_o};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL underrun k=%0d got %h want %h", k, obs, exp);
            end
            tick();
        end
        fifo.fifo_empty = 1'b0;
        underrun_clr    = 1'b0;
    endtask

    task automatic test_clamp_polarity();
        logic [2:0] obs, exp;
        ctrl_ven = 1'b0;
        tick();
        thlen       = 12'd5;
        ctrl_hsyncl = 1'b1;
        start(2'b00);
        for (int k = 0; k < 90; k++) begin
            exp = {(k % 9) == 8, (k % 45) == 44, (k < 2) ? 1'b1 : !(((k - 2) % 9) < 2)};
            obs = {eol_o, eof_o, hsync_o};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL clamp_polarity k=%0d got %b want %b", k, obs, exp);
            end
            tick();
        end
        ctrl_ven = 1'b0;
        tick();
        thlen       = 12'd9;
        ctrl_hsyncl = 1'b0;
    endtask

    task automatic test_ven_drop();
        int base;
        logic [25:0] obs, exp;
        logic [3:0]  obs2, exp2;
        start(2'b00);
        base = pop_cnt;
        for (int k = 0; k < 30; k++) begin
            if (k == 25) ctrl_ven = 1'b0;
            if (k >= 26) begin
                exp = {1'b0, (k >= 27), (k == 26) ? word_of(base) : 24'd0};
                obs = {fifo.fifo_rreq, blank_o, r_o, g_o, b_o};
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL ven_drop k=%0d got %h want %h", k, obs, exp);
                end
            end
            tick();
        end
        ctrl_ven = 1'b1;
        tick();
        for (int k = 0; k < 13; k++) begin
            exp2 = {(k >= 2) && (((k - 2) % 10) < 2), (k >= 2) && (k < 12), 1'b1, k == 9};
            obs2 = {hsync_o, vsync_o, blank_o, eol_o};
            n_checks++;
            if (obs2 !== exp2) begin
                n_fail++;
                $display("FAIL ven_restart k=%0d got %b want %b", k, obs2, exp2);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int base;
        logic [32:0] obs;
        start(2'b00);
        base = pop_cnt;
        repeat (26) tick();
        n_checks++;
        if ({r_o, g_o, b_o} !== word_of(base)) begin
            n_fail++;
            $display("FAIL reset_mid_pre got %h want %h", {r_o, g_o, b_o}, word_of(base));
        end
        nrst_i = 1'b0;
        #1;
        obs = {fifo.fifo_rreq, eol_o, eof_o, underrun_o, hsync_o, vsync_o, blank_o,
               r_o, g_o, b_o};
        n_checks++;
        if (obs !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_mid got %h want %h", obs, 33'd0);
        end
        #3;
        nrst_i = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        fifo.fifo_empty = 1'b0;
        test_reset();
        test_baseline();
        test_grey();
        test_double();
        test_mode_midframe();
        test_underrun();
        test_clamp_polarity();
        test_ven_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
